// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared types and constants for the multi-precision add sequencer.
//   state_t  sequencer FSM state (IDLE, CHAIN)
//   LIMB_W   limb width of the carry-lookahead adder
//   idx_w()  width of a limb index for a given maximum limb count
package mp_add_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CHAIN = 1'b1
  } state_t;

  localparam int LIMB_W = 16;

  function automatic int idx_w(input int max_limbs);
    return (max_limbs > 1) ? $clog2(max_limbs) : 1;
  endfunction

endpackage

// File: rtl/mp_add_seq_cla.sv
// cla_add16: purely combinational 16-bit carry-lookahead adder.
// Four 4-bit groups; the group carries come from a second lookahead level
// over the group generate/propagate terms.
//   a, b   addends
//   cin    carry in
//   sum    a + b + cin, modulo 2^16
//   cout   carry out of bit 15
module cla_add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  // Carries out of bits 0..3 of a 4-bit block, fully expanded.
  function automatic logic [3:0] la4(input logic [3:0] g4, input logic [3:0] p4,
                                     input logic ci);
    logic [3:0] co;
    co[0] = g4[0] | (p4[0] & ci);
    co[1] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & ci);
    co[2] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
          | (p4[2] & p4[1] & p4[0] & ci);
    co[3] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
          | (p4[3] & p4[2] & p4[1] & g4[0]) | (p4[3] & p4[2] & p4[1] & p4[0] & ci);
    return co;
  endfunction

  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  cg;

  always_comb begin
    logic [3:0] t;
    t  = '0;
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      t     = la4(g[4*k +: 4], p[4*k +: 4], 1'b0);
      gg[k] = t[3];
      gp[k] = &p[4*k +: 4];
    end
    cg[0]   = cin;
    cg[4:1] = la4(gg, gp, cin);
    for (int k = 0; k < 4; k++) begin
      t          = la4(g[4*k +: 4], p[4*k +: 4], cg[k]);
      c[4*k]     = cg[k];
      c[4*k + 1] = t[0];
      c[4*k + 2] = t[1];
      c[4*k + 3] = t[2];
    end
    sum  = p ^ c;
    cout = cg[4];
  end

endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add sequencer in front of a 16-bit CLA.
// Takes limb pairs LSB first on a valid/ready stream, chains the carry
// between limbs, and registers each limb sum in a one-entry output stage.
//
// Optional feature: define MP_ADD_SUB_EN to enable subtraction. in_sub on the
// first limb is latched for the whole operation; B is inverted and the
// initial carry is 1, so out_cout=1 on the last limb means no borrow.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready            input limb handshake
//   in_a, in_b, in_last, in_sub  limb pair, last-limb flag, subtract request
//   out_valid/out_ready          output limb handshake
//   out_sum, out_idx, out_last   limb sum, limb index (0 = LSB), final limb
//   out_cout, out_err            final carry (last limb only), overflow abort
//
// state | meaning
// IDLE  | next accepted limb is limb 0; carry in is the initial carry
// CHAIN | mid-operation; carry in is carry_q from the previous limb
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int WIDTH     = 16,  // must equal LIMB_W
  parameter int MAX_LIMBS = 8    // >= 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  input  logic                         in_last,
  input  logic                         in_sub,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_sum,
  output logic [idx_w(MAX_LIMBS)-1:0]  out_idx,
  output logic                         out_last,
  output logic                         out_cout,
  output logic                         out_err
);

  localparam int IDX_W = idx_w(MAX_LIMBS);
  localparam logic [IDX_W-1:0] CNT_MAX = IDX_W'(MAX_LIMBS - 1);

  state_t           state_q;
  logic             carry_q;
  logic [IDX_W-1:0] limb_cnt;

  logic             accept, first, force_last, is_last;
  logic             add_cin, add_cout, sub_eff;
  logic [WIDTH-1:0] add_b, add_sum;

`ifdef MP_ADD_SUB_EN
  logic sub_q;
`else
  // in_sub has no effect in an add-only build.
  logic unused_in_sub;
  assign unused_in_sub = in_sub;
`endif

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    first = (state_q == IDLE);
`ifdef MP_ADD_SUB_EN
    sub_eff = first ? in_sub : sub_q;
`else
    sub_eff = 1'b0;
`endif
    add_b      = sub_eff ? ~in_b : in_b;
    // Subtraction starts with carry 1 (two's complement of B).
    add_cin    = first ? sub_eff : carry_q;
    // Reaching the last index without in_last aborts the operation here.
    force_last = (limb_cnt == CNT_MAX) && !in_last;
    is_last    = in_last || force_last;
  end

  cla_add16 u_cla (
    .a    (in_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      carry_q   <= 1'b0;
      limb_cnt  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_err   <= 1'b0;
`ifdef MP_ADD_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else if (accept) begin
      carry_q   <= add_cout;
      out_valid <= 1'b1;
      out_sum   <= add_sum;
      out_idx   <= limb_cnt;
      out_last  <= is_last;
      out_cout  <= is_last ? add_cout : 1'b0;
      out_err   <= force_last;
      limb_cnt  <= is_last ? '0 : limb_cnt + IDX_W'(1);
      state_q   <= is_last ? IDLE : CHAIN;
`ifdef MP_ADD_SUB_EN
      if (first) sub_q <= in_sub;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
